// File: rtl/mem_burst_reader_if.sv
// Output stream bundle of the burst reader.
// Registered data/valid/last toward the consumer, ready back.
interface mem_burst_reader_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mem_burst_reader.sv
// Burst read engine: walks a comb-read RAM from start_addr for
// length words and emits them on a registered valid/ready stream.
module mem_burst_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int ADDR  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ADDR-1:0]  start_addr,
    input  logic [ADDR:0]    length,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [ADDR-1:0]  mem_read_addr,
    input  logic [WIDTH-1:0] mem_read_data,
    mem_burst_reader_if.master strm
);
    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [ADDR:0]   DEPTH_W = (ADDR+1)'(DEPTH);
    localparam logic [ADDR-1:0] LAST_A  = ADDR'(DEPTH - 1);
    localparam logic [ADDR:0]   ONE_W   = (ADDR+1)'(1);

    state_t           state_q, state_d;
    logic [ADDR-1:0]  ptr_q, ptr_d;
    logic [ADDR:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic [ADDR:0]    sa_ext;
    logic             slot_free;

    assign sa_ext    = {1'b0, start_addr};
    assign slot_free = !valid_q || strm.out_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        // Out-of-range start addresses fold back into the RAM
                        if (sa_ext >= DEPTH_W)
                            ptr_d = ADDR'(sa_ext - DEPTH_W);
                        else
                            ptr_d = start_addr;
                        cnt_d   = length;
                        state_d = STREAM;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (abort) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = IDLE;
                end else if (slot_free) begin
                    if (cnt_q != '0) begin
                        data_d  = mem_read_data;
                        valid_d = 1'b1;
                        last_d  = (cnt_q == ONE_W);
                        ptr_d   = (ptr_q == LAST_A) ? '0 : ptr_q + 1'b1;
                        cnt_d   = cnt_q - ONE_W;
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign busy           = (state_q == STREAM);
    assign done           = done_q;
    assign mem_read_addr  = ptr_q;
    assign strm.out_data  = data_q;
    assign strm.out_valid = valid_q;
    assign strm.out_last  = last_q;
endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader with an expected-beat queue
// checked against every accepted stream beat.
module tb_mem_burst_reader;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int ADDR  = 4;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [ADDR-1:0]  start_addr = '0;
    logic [ADDR:0]    length = '0;
    logic             abort = 1'b0;
    logic             busy, done;
    logic [ADDR-1:0]  mem_read_addr;
    logic [WIDTH-1:0] mem_read_data;
    logic [WIDTH-1:0] mem [DEPTH];

    mem_burst_reader_if #(.WIDTH(WIDTH)) strm ();

    mem_burst_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .start_addr(start_addr),
        .length(length),
        .abort(abort),
        .busy(busy),
        .done(done),
        .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data),
        .strm(strm.master)
    );

    always #5 clk = ~clk;
    assign mem_read_data = mem[mem_read_addr];

    beat_t q[$];
    int n_assert = 0;
    int n_fail   = 0;
    int n_beats  = 0;
    int n_done   = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: sampled on the falling edge, ahead of the handshake edge
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic             prev_last;
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (done) n_done++;
            if (prev_stall) begin
                check("stall_valid", {31'b0, strm.out_valid}, 1);
                check("stall_data", {24'b0, strm.out_data}, {24'b0, prev_data});
                check("stall_last", {31'b0, strm.out_last}, {31'b0, prev_last});
            end
            prev_stall = strm.out_valid && !strm.out_ready && !abort;
            prev_data  = strm.out_data;
            prev_last  = strm.out_last;
            if (strm.out_valid && strm.out_ready && !abort) begin
                n_beats++;
                if (q.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("beat_data", {24'b0, strm.out_data}, {24'b0, e.data});
                    check("beat_last", {31'b0, strm.out_last}, {31'b0, e.last});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int a, input int len);
        beat_t e;
        for (int i = 0; i < len; i++) begin
            e.data = mem[(a + i) % DEPTH];
            e.last = (i == len - 1);
            q.push_back(e);
        end
        start      = 1'b1;
        start_addr = ADDR'(a);
        length     = (ADDR+1)'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = done;
        end
        check(tag, {31'b0, seen}, 1);
    endtask

    task automatic scen_basic();
        do_start(3, 4);
        check("s1_busy", {31'b0, busy}, 1);
        check("s1_valid0", {31'b0, strm.out_valid}, 0);
        tick();
        check("s1_first", {24'b0, strm.out_data}, 32'h13);
        check("s1_first_last", {31'b0, strm.out_last}, 0);
        tick(); tick(); tick();
        check("s1_fourth", {24'b0, strm.out_data}, 32'h16);
        check("s1_fourth_last", {31'b0, strm.out_last}, 1);
        check("s1_done_early", {31'b0, done}, 0);
        tick();
        check("s1_done", {31'b0, done}, 1);
        check("s1_valid_off", {31'b0, strm.out_valid}, 0);
        check("s1_busy_off", {31'b0, busy}, 0);
        tick();
        check("s1_done_pulse", {31'b0, done}, 0);
        check("s1_sb_drained", q.size(), 0);
    endtask

    initial begin
        int b0, d0;
        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i + 8'h10);
        strm.out_ready = 1'b1;
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_valid", {31'b0, strm.out_valid}, 0);
        check("rst_last", {31'b0, strm.out_last}, 0);
        check("rst_data", {24'b0, strm.out_data}, 0);
        check("rst_addr", {28'b0, mem_read_addr}, 0);
        #20 rst_n = 1'b1;
        tick();

        scen_basic();

        do_start(14, 4);
        check("s2_addr14", {28'b0, mem_read_addr}, 14);
        tick();
        check("s2_addr15", {28'b0, mem_read_addr}, 15);
        tick();
        check("s2_addr_wrap", {28'b0, mem_read_addr}, 0);
        wait_done("s2_done", 10);
        check("s2_sb_drained", q.size(), 0);

        b0 = n_beats;
        do_start(0, 3);
        tick();
        tick();
        strm.out_ready = 1'b0;
        tick();
        tick();
        strm.out_ready = 1'b1;
        wait_done("s3_done", 10);
        check("s3_beats", n_beats - b0, 3);
        check("s3_sb_drained", q.size(), 0);

        do_start(7, 0);
        check("s4_done", {31'b0, done}, 1);
        check("s4_busy", {31'b0, busy}, 0);
        check("s4_valid", {31'b0, strm.out_valid}, 0);
        tick();
        check("s4_done_pulse", {31'b0, done}, 0);
        check("s4_valid_after", {31'b0, strm.out_valid}, 0);

        b0 = n_beats;
        d0 = n_done;
        do_start(0, 8);
        tick(); tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        q.delete();
        check("s5_valid_off", {31'b0, strm.out_valid}, 0);
        check("s5_busy_off", {31'b0, busy}, 0);
        tick(); tick(); tick();
        check("s5_no_done", n_done - d0, 0);
        check("s5_beats", n_beats - b0, 2);
        do_start(5, 1);
        tick();
        check("s5_single", {24'b0, strm.out_data}, 32'h15);
        check("s5_single_last", {31'b0, strm.out_last}, 1);
        wait_done("s5_done", 5);
        check("s5_sb_drained", q.size(), 0);

        do_start(3, 4);
        start      = 1'b1;
        start_addr = 4'd9;
        length     = 5'd2;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        check("s6_valid", {31'b0, strm.out_valid}, 0);
        check("s6_busy", {31'b0, busy}, 0);
        check("s6_done", {31'b0, done}, 0);
        check("s6_addr", {28'b0, mem_read_addr}, 0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("s6_no_done", {31'b0, done}, 0);
        scen_basic();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
